// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
//   Shared types and constants for the MAC accumulator and its round/saturate
//   helper.
//   - state_t     : control states of the accumulator
//   - MAC_*       : default widths of the datapath
//   - OUT_MAX/MIN : clip bounds of the default signed result width
//   - ROUND_HALF  : 2^(FRAC_SHIFT-1), added before the arithmetic shift
// ---------------------------------------------------------------------------
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUTPUT
    } state_t;

    localparam int MAC_IN_W       = 64;
    localparam int MAC_OUT_W      = 32;
    localparam int MAC_ACC_W      = 80;
    localparam int MAC_FRAC_SHIFT = 16;
    localparam int MAC_CNT_W      = 16;

    localparam logic signed [MAC_OUT_W-1:0] OUT_MAX = {1'b0, {(MAC_OUT_W-1){1'b1}}};
    localparam logic signed [MAC_OUT_W-1:0] OUT_MIN = {1'b1, {(MAC_OUT_W-1){1'b0}}};

    localparam logic signed [MAC_ACC_W-1:0] ROUND_HALF =
        MAC_ACC_W'(1) << (MAC_FRAC_SHIFT - 1);

endpackage

// File: rtl/fxp_round_sat.sv
// ---------------------------------------------------------------------------
// fxp_round_sat
//   Combinational fixed-point narrowing: adds one half LSB of the output
//   grid, shifts right arithmetically by FRAC_SHIFT (round half toward +inf),
//   and clips to the signed OUT_W range.
// Ports:
//   acc  in   ACC_W  signed wide value
//   res  out  OUT_W  rounded, clipped value
//   sat  out  1      high when res was clipped
// ---------------------------------------------------------------------------
module fxp_round_sat
    import mac_pkg::*;
#(
    parameter int                      ACC_W      = MAC_ACC_W,
    parameter int                      OUT_W      = MAC_OUT_W,
    parameter int                      FRAC_SHIFT = MAC_FRAC_SHIFT,
    parameter logic signed [OUT_W-1:0] SAT_MAX    = OUT_MAX,
    parameter logic signed [OUT_W-1:0] SAT_MIN    = OUT_MIN,
    parameter logic signed [ACC_W-1:0] HALF       = ROUND_HALF
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] res,
    output logic                    sat
);

    // Bounds widened to the one-bit-wider working width so the compare is
    // exact even when the half-LSB add carries into the top bit.
    localparam logic signed [ACC_W:0] MAX_EXT =
        {{(ACC_W+1-OUT_W){SAT_MAX[OUT_W-1]}}, SAT_MAX};
    localparam logic signed [ACC_W:0] MIN_EXT =
        {{(ACC_W+1-OUT_W){SAT_MIN[OUT_W-1]}}, SAT_MIN};

    // Returns {sat, result}.
    function automatic logic [OUT_W:0] round_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] sum;
        logic signed [ACC_W:0] shr;
        sum = {a[ACC_W-1], a} + {HALF[ACC_W-1], HALF};
        shr = sum >>> FRAC_SHIFT;
        if (shr > MAX_EXT) begin
            return {1'b1, SAT_MAX};
        end else if (shr < MIN_EXT) begin
            return {1'b1, SAT_MIN};
        end else begin
            return {1'b0, shr[OUT_W-1:0]};
        end
    endfunction

    always_comb begin
        {sat, res} = round_sat(acc);
    end

endmodule

// File: rtl/mac_accumulator.sv
// ---------------------------------------------------------------------------
// mac_accumulator
//   Accumulates a vector of signed products plus a Q16.16 bias into a wide
//   accumulator and emits one rounded, saturated result per vector.
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      product beat valid
//   in_ready   out  1      beat can be accepted (low while a result waits)
//   in_data    in   IN_W   signed product
//   in_last    in   1      final beat of the vector
//   in_bias    in   OUT_W  signed bias, sampled on the first beat only
//   out_valid  out  1      result available
//   out_ready  in   1      downstream accepts the result
//   out_data   out  OUT_W  rounded, saturated result
//   out_sat    out  1      result was clipped
//   out_count  out  CNT_W  number of terms, saturating at all-ones
// ---------------------------------------------------------------------------
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int IN_W       = MAC_IN_W,
    parameter int OUT_W      = MAC_OUT_W,
    parameter int ACC_W      = MAC_ACC_W,
    parameter int FRAC_SHIFT = MAC_FRAC_SHIFT,
    parameter int CNT_W      = MAC_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_last,
    input  logic signed [OUT_W-1:0] in_bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat,
    output logic [CNT_W-1:0]        out_count
);

    localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) << (FRAC_SHIFT - 1);

    state_t                  state_p0;
    state_t                  state_nxt;
    logic signed [ACC_W-1:0] acc_p0;
    logic [CNT_W-1:0]        cnt_p0;

    logic                    vld_p1;
    logic signed [OUT_W-1:0] data_p1;
    logic                    sat_p1;
    logic [CNT_W-1:0]        cnt_p1;

    logic                    beat;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] data_ext;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic signed [OUT_W-1:0] res_c;
    logic                    sat_c;

    // ---- stage p0: beat acceptance and accumulation ----
    assign in_ready = (state_p0 != OUTPUT);
    assign beat     = in_valid && in_ready;

    assign bias_ext = ACC_W'(in_bias) <<< FRAC_SHIFT;
    assign data_ext = ACC_W'(in_data);

    // The first beat of a vector starts from the shifted bias instead of the
    // running sum, so a one-beat vector needs no extra cycle.
    assign acc_base = (state_p0 == IDLE) ? bias_ext : acc_p0;
    assign acc_nxt  = acc_base + data_ext;

    always_comb begin
        cnt_nxt = cnt_p0;
        if (state_p0 == IDLE) begin
            cnt_nxt = CNT_W'(1);
        end else if (cnt_p0 != {CNT_W{1'b1}}) begin
            cnt_nxt = cnt_p0 + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            IDLE: begin
                if (beat) begin
                    state_nxt = in_last ? OUTPUT : ACCUM;
                end
            end
            ACCUM: begin
                if (beat && in_last) begin
                    state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The result is taken from the sum that includes the last beat, so the
    // narrowing runs on acc_nxt rather than the registered accumulator.
    fxp_round_sat #(
        .ACC_W      (ACC_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (FRAC_SHIFT),
        .SAT_MAX    (SAT_MAX),
        .SAT_MIN    (SAT_MIN),
        .HALF       (HALF)
    ) u_round_sat (
        .acc (acc_nxt),
        .res (res_c),
        .sat (sat_c)
    );

    // ---- stage p1: registered result held until accepted ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_p0 <= IDLE;
            acc_p0   <= '0;
            cnt_p0   <= '0;
            vld_p1   <= 1'b0;
            data_p1  <= '0;
            sat_p1   <= 1'b0;
            cnt_p1   <= '0;
        end else begin
            state_p0 <= state_nxt;
            if (beat) begin
                acc_p0 <= acc_nxt;
                cnt_p0 <= cnt_nxt;
                if (in_last) begin
                    vld_p1  <= 1'b1;
                    data_p1 <= res_c;
                    sat_p1  <= sat_c;
                    cnt_p1  <= cnt_nxt;
                end
            end
            if (vld_p1 && out_ready) begin
                vld_p1 <= 1'b0;
                acc_p0 <= '0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_sat   = sat_p1;
    assign out_count = cnt_p1;

endmodule

// File: tb/tb_mac_accumulator.sv
// ---------------------------------------------------------------------------
// tb_mac_accumulator
//   Directed bench for mac_accumulator: accumulation, bias, rounding,
//   saturation, backpressure and mid-vector reset with hand-computed results.
// ---------------------------------------------------------------------------
module tb_mac_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_last;
    logic [31:0] in_bias;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;
    logic [15:0] out_count;

    int checks;
    int failures;

    mac_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bias   (in_bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one beat for a single rising edge; returns at the next
    // falling edge with inputs idle again.
    task automatic beat(input logic [63:0] d, input logic [31:0] b, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_bias  = b;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        in_bias  = '0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [31:0] d,
                                input logic s, input logic [15:0] c);
        chk({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
        chk({tag, "_data"},  64'(out_data),  64'(d));
        chk({tag, "_sat"},   64'(out_sat),   64'(s));
        chk({tag, "_count"}, 64'(out_count), 64'(c));
        chk({tag, "_inrdy"}, 64'(in_ready),  64'(1'b0));
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_rel_valid"}, 64'(out_valid), 64'(1'b0));
        chk({tag, "_rel_inrdy"}, 64'(in_ready),  64'(1'b1));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_bias   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_data",  64'(out_data),  64'(0));
        chk("rst_sat",   64'(out_sat),   64'(1'b0));
        chk("rst_count", 64'(out_count), 64'(0));
        chk("rst_inrdy", 64'(in_ready),  64'(1'b1));
        rst_n = 1'b1;
        @(negedge clk);

        // Three terms of 1.0 each; bias on later beats must be ignored.
        beat(64'h0000_0001_0000_0000, 32'h0, 1'b0);
        beat(64'h0000_0001_0000_0000, 32'h1234_5678, 1'b0);
        chk("acc3_early_valid", 64'(out_valid), 64'(1'b0));
        beat(64'h0000_0001_0000_0000, 32'h7FFF_0000, 1'b1);
        check_result("acc3", 32'h0003_0000, 1'b0, 16'd3);
        release_result("acc3");

        // One-beat vector: 0.5 bias + 0.5 product.
        beat(64'h0000_0000_8000_0000, 32'h0000_8000, 1'b1);
        check_result("one_bias", 32'h0001_0000, 1'b0, 16'd1);
        release_result("one_bias");

        // Rounding at exactly half, half below zero, and just under.
        beat(64'h0000_0000_0000_8000, 32'h0, 1'b1);
        check_result("rnd_half", 32'h0000_0001, 1'b0, 16'd1);
        release_result("rnd_half");

        beat(64'hFFFF_FFFF_FFFF_8000, 32'h0, 1'b1);
        check_result("rnd_neg_half", 32'h0000_0000, 1'b0, 16'd1);
        release_result("rnd_neg_half");

        beat(64'hFFFF_FFFF_FFFF_7FFF, 32'h0, 1'b1);
        check_result("rnd_neg", 32'hFFFF_FFFF, 1'b0, 16'd1);
        release_result("rnd_neg");

        // Positive and negative saturation.
        beat(64'h7FFF_FFFF_0000_0000, 32'h0, 1'b0);
        beat(64'h7FFF_FFFF_0000_0000, 32'h0, 1'b1);
        check_result("sat_pos", 32'h7FFF_FFFF, 1'b1, 16'd2);
        release_result("sat_pos");

        beat(64'h8000_0000_0000_0000, 32'h0, 1'b0);
        beat(64'h8000_0000_0000_0000, 32'h0, 1'b1);
        check_result("sat_neg", 32'h8000_0000, 1'b1, 16'd2);
        release_result("sat_neg");

        // Backpressure: beats offered while the result waits are dropped.
        beat(64'h0000_0002_0000_0000, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            beat(64'h0000_0007_0000_0000, 32'h0001_0000, 1'(i[0]));
            check_result("bp_hold", 32'h0002_0000, 1'b0, 16'd1);
        end
        release_result("bp");
        beat(64'h0000_0005_0000_0000, 32'h0, 1'b1);
        check_result("bp_next", 32'h0005_0000, 1'b0, 16'd1);
        release_result("bp_next");

        // Reset mid-vector discards the partial sum and clears outputs.
        beat(64'h0000_0001_0000_0000, 32'h0, 1'b0);
        beat(64'h0000_0001_0000_0000, 32'h0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_valid", 64'(out_valid), 64'(1'b0));
        chk("mid_rst_data",  64'(out_data),  64'(0));
        chk("mid_rst_sat",   64'(out_sat),   64'(1'b0));
        chk("mid_rst_count", 64'(out_count), 64'(0));
        chk("mid_rst_inrdy", 64'(in_ready),  64'(1'b1));
        beat(64'h0000_0001_0000_0000, 32'h0, 1'b1);
        check_result("post_rst", 32'h0001_0000, 1'b0, 16'd1);
        release_result("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
